// File: rtl/nios_cpu_mul_combine.sv
// Reduces the three 16x16 partial products of the Nios multiplier to the low
// 32-bit word of the 32x32 product, through a two-stage valid/ready pipeline.
module nios_cpu_mul_combine #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      M_mul_cell_p1,
  input  logic [31:0]      M_mul_cell_p2,
  input  logic [31:0]      M_mul_cell_p3,
  input  logic             M_mul_valid,
  input  logic [TAG_W-1:0] M_mul_tag,
  output logic             M_mul_stall,
  input  logic             W_ready,
  output logic             W_mul_valid,
  output logic [31:0]      W_mul_result,
  output logic [TAG_W-1:0] W_mul_tag
);

  // Cross terms only matter below bit 16; their upper halves land above bit 31.
  function automatic logic [15:0] mid_fold(input logic [15:0] p2_lo, input logic [15:0] p3_lo);
    return p2_lo + p3_lo;
  endfunction

  function automatic logic [31:0] low_word(input logic [31:0] lo, input logic [15:0] mid);
    return lo + {mid, 16'h0000};
  endfunction

  logic             s1_valid_r;
  logic [31:0]      s1_lo_r;
  logic [15:0]      s1_mid_r;
  logic [TAG_W-1:0] s1_tag_r;

  logic             s2_adv_s;
  logic             s1_adv_s;
  logic             accept_s;
  logic             unused_hi_s;

  assign unused_hi_s = ^{M_mul_cell_p2[31:16], M_mul_cell_p3[31:16]};

  // Elastic handshake: a stage may advance when its successor is empty or draining.
  always_comb begin
    s2_adv_s    = ~W_mul_valid | W_ready;
    s1_adv_s    = ~s1_valid_r | s2_adv_s;
    accept_s    = M_mul_valid & s1_adv_s;
    M_mul_stall = ~s1_adv_s;
  end

  // Stage 1: capture p1 and the folded cross-term sum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_lo_r    <= 32'h0000_0000;
      s1_mid_r   <= 16'h0000;
      s1_tag_r   <= '0;
    end else if (s1_adv_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_lo_r  <= M_mul_cell_p1;
        s1_mid_r <= mid_fold(M_mul_cell_p2[15:0], M_mul_cell_p3[15:0]);
        s1_tag_r <= M_mul_tag;
      end
    end
  end

  // Stage 2: final add toward writeback; holds everything while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      W_mul_valid  <= 1'b0;
      W_mul_result <= 32'h0000_0000;
      W_mul_tag    <= '0;
    end else if (s2_adv_s) begin
      W_mul_valid <= s1_valid_r;
      if (s1_valid_r) begin
        W_mul_result <= low_word(s1_lo_r, s1_mid_r);
        W_mul_tag    <= s1_tag_r;
      end
    end
  end

endmodule

// File: tb/tb_nios_cpu_mul_combine.sv
// Directed-vector and random self-checking bench for nios_cpu_mul_combine.
module tb_nios_cpu_mul_combine;

  typedef struct {
    logic [31:0] p1;
    logic [31:0] p2;
    logic [31:0] p3;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3;
  logic        M_mul_valid;
  logic [4:0]  M_mul_tag;
  logic        M_mul_stall;
  logic        W_ready;
  logic        W_mul_valid;
  logic [31:0] W_mul_result;
  logic [4:0]  W_mul_tag;

  logic [31:0] drv_exp;
  logic [36:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  logic        prev_hold = 1'b0;
  logic [31:0] held_res;
  logic [4:0]  held_tag;

  vec_t vecs[7];

  nios_cpu_mul_combine #(.TAG_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .M_mul_cell_p1(M_mul_cell_p1), .M_mul_cell_p2(M_mul_cell_p2), .M_mul_cell_p3(M_mul_cell_p3),
    .M_mul_valid(M_mul_valid), .M_mul_tag(M_mul_tag), .M_mul_stall(M_mul_stall),
    .W_ready(W_ready), .W_mul_valid(W_mul_valid), .W_mul_result(W_mul_result), .W_mul_tag(W_mul_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                        input logic [4:0] tag, input logic [31:0] exp);
    M_mul_cell_p1 = p1;
    M_mul_cell_p2 = p2;
    M_mul_cell_p3 = p3;
    M_mul_tag     = tag;
    drv_exp       = exp;
    M_mul_valid   = 1'b1;
  endtask

  task automatic set_src(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    logic [31:0] a_lo, a_hi, b_lo, b_hi;
    a_lo = {16'h0000, a[15:0]};
    a_hi = {16'h0000, a[31:16]};
    b_lo = {16'h0000, b[15:0]};
    b_hi = {16'h0000, b[31:16]};
    set_in(a_lo * b_lo, a_lo * b_hi, a_hi * b_lo, tag, a * b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: records accepted inputs, checks outputs in order and output stability.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checks++;
        if (!W_mul_valid || W_mul_result !== held_res || W_mul_tag !== held_tag) begin
          errors++;
          $display("FAIL hold_stable: actual=%b/%h/%h required=1/%h/%h",
                   W_mul_valid, W_mul_result, W_mul_tag, held_res, held_tag);
        end
      end
      if (W_mul_valid && W_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: actual=%h/%h required=no output", W_mul_result, W_mul_tag);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          checks++;
          if (W_mul_result !== e[31:0] || W_mul_tag !== e[36:32]) begin
            errors++;
            $display("FAIL sb_data: actual=%h/%h required=%h/%h",
                     W_mul_result, W_mul_tag, e[31:0], e[36:32]);
          end
        end
      end
      prev_hold = W_mul_valid && !W_ready;
      held_res  = W_mul_result;
      held_tag  = W_mul_tag;
      if (M_mul_valid && !M_mul_stall) exp_q.push_back({M_mul_tag, drv_exp});
    end
  end

  initial begin
    logic [9:0] vpat;
    logic       stall_seen;
    logic       hold;
    int         sent;

    vecs[0] = '{32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 5'd3,  32'h00000001};
    vecs[1] = '{32'h00023450, 32'h00000000, 32'h00000010, 5'd7,  32'h00123450};
    vecs[2] = '{32'h00000000, 32'h00000000, 32'h00000000, 5'd0,  32'h00000000};
    vecs[3] = '{32'h00000000, 32'h0000FFFF, 32'h00000001, 5'd31, 32'h00000000};
    vecs[4] = '{32'h12345678, 32'hABCD0000, 32'h55550000, 5'd10, 32'h12345678};
    vecs[5] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'd1,  32'h0000FFFF};
    vecs[6] = '{32'h00000015, 32'h0000000F, 32'h00000000, 5'd20, 32'h000F0015};

    reset_n = 1'b0;
    M_mul_valid = 1'b0;
    M_mul_cell_p1 = 32'h0; M_mul_cell_p2 = 32'h0; M_mul_cell_p3 = 32'h0;
    M_mul_tag = 5'd0; drv_exp = 32'h0;
    W_ready = 1'b1;
    #1;
    chk("rst_valid", {31'd0, W_mul_valid}, 32'd0);
    chk("rst_result", W_mul_result, 32'd0);
    chk("rst_tag", {27'd0, W_mul_tag}, 32'd0);
    chk("rst_stall", {31'd0, M_mul_stall}, 32'd0);
    @(negedge clk); @(negedge clk);
    #2 reset_n = 1'b1;
    tick();

    // Directed vectors, one at a time, with latency check.
    for (int i = 0; i < 7; i++) begin
      set_in(vecs[i].p1, vecs[i].p2, vecs[i].p3, vecs[i].tag, vecs[i].exp);
      #1 chk("vec_stall", {31'd0, M_mul_stall}, 32'd0);
      tick();
      M_mul_valid = 1'b0;
      chk("vec_lat1_valid", {31'd0, W_mul_valid}, 32'd0);
      tick();
      chk("vec_lat2_valid", {31'd0, W_mul_valid}, 32'd1);
      chk("vec_result", W_mul_result, vecs[i].exp);
      chk("vec_tag", {27'd0, W_mul_tag}, {27'd0, vecs[i].tag});
      tick();
    end

    // Back-to-back stream of 8.
    vpat = 10'd0;
    stall_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_in(32'(i + 1), 32'h0, 32'(i), 5'(i), (32'(i) << 16) + 32'(i + 1));
      #1 if (M_mul_stall) stall_seen = 1'b1;
      tick();
      vpat[i] = W_mul_valid;
    end
    M_mul_valid = 1'b0;
    tick(); vpat[8] = W_mul_valid;
    tick(); vpat[9] = W_mul_valid;
    chk("b2b_valid_pattern", {22'd0, vpat}, {22'd0, 10'b0111111110});
    chk("b2b_stall_seen", {31'd0, stall_seen}, 32'd0);

    // Backpressure: two buffered, third stalls until W_ready rises.
    W_ready = 1'b0;
    set_in(32'h1, 32'h0, 32'h0, 5'd1, 32'h00000001);
    #1 chk("bp_stall_a", {31'd0, M_mul_stall}, 32'd0);
    tick();
    set_in(32'h2, 32'h0, 32'h0, 5'd2, 32'h00000002);
    #1 chk("bp_stall_b", {31'd0, M_mul_stall}, 32'd0);
    tick();
    set_in(32'h100, 32'h1, 32'h0, 5'd3, 32'h00010100);
    #1 chk("bp_stall_c", {31'd0, M_mul_stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", {31'd0, W_mul_valid}, 32'd1);
      chk("bp_hold_result", W_mul_result, 32'h00000001);
      chk("bp_hold_stall", {31'd0, M_mul_stall}, 32'd1);
    end
    W_ready = 1'b1;
    #1 chk("bp_release_stall", {31'd0, M_mul_stall}, 32'd0);
    tick();
    M_mul_valid = 1'b0;
    chk("bp_next_result", W_mul_result, 32'h00000002);
    tick(); tick(); tick();
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset while both stages hold data.
    W_ready = 1'b0;
    set_in(32'h55, 32'h0, 32'h0, 5'd9, 32'h55);
    tick();
    set_in(32'h66, 32'h0, 32'h0, 5'd10, 32'h66);
    tick();
    M_mul_valid = 1'b0;
    chk("mr_full_stall", {31'd0, M_mul_stall}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_valid", {31'd0, W_mul_valid}, 32'd0);
    chk("mr_stall", {31'd0, M_mul_stall}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    #2 reset_n = 1'b1;
    W_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mr_no_output", {31'd0, W_mul_valid}, 32'd0);
    end

    // Random operands with random valid and ready.
    hold = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 20000 && sent < 10000; cyc++) begin
      if (!hold) begin
        if ($urandom_range(3) != 0) set_src($urandom, $urandom, 5'($urandom_range(31)));
        else M_mul_valid = 1'b0;
      end
      W_ready = ($urandom_range(3) != 0);
      #3;
      hold = M_mul_valid && M_mul_stall;
      if (M_mul_valid && !M_mul_stall) sent++;
      @(posedge clk);
      #1;
    end
    M_mul_valid = 1'b0;
    W_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    chk("rand_sent", 32'(sent), 32'd10000);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_cpu_mul_combine.md
# nios_cpu_mul_combine

Downstream stage of the Nios CPU hardware multiplier. It accepts the three registered 16x16 partial products from the multiply cell and reduces them to the 32-bit low word of the 32x32 product: p1 + ((p2 + p3) << 16) mod 2^32. It delivers that word to writeback through a two-stage elastic pipeline with valid/ready backpressure, and carries the destination-register tag alongside the data.

## Interface
- TAG_W, 5, width of the destination-register tag carried with each result

- clk  in  1  system clock; all registers rise-edge
- reset_n  in  1  asynchronous, active-low reset
- M_mul_cell_p1  in  32  src1[15:0] * src2[15:0], unsigned
- M_mul_cell_p2  in  32  src1[15:0] * src2[31:16], unsigned
- M_mul_cell_p3  in  32  src1[31:16] * src2[15:0], unsigned
- M_mul_valid  in  1  partial products and tag are valid this cycle
- M_mul_tag  in  TAG_W  destination register index
- M_mul_stall  out  1  combiner cannot accept this cycle; upstream must hold inputs and M_mul_valid
- W_ready  in  1  writeback accepts W_mul_result this cycle
- W_mul_valid  out  1  result and tag are valid
- W_mul_result  out  32  low 32 bits of the product
- W_mul_tag  out  TAG_W  tag of W_mul_result

## Operation
- **Stage S1 (registers s1_valid, s1_lo, s1_mid, s1_tag)**
  - On accept, s1_lo <= p1.
  - s1_mid <= (p2[15:0] + p3[15:0]) mod 2^16.
  - p2[31:16] and p3[31:16] are discarded, since they only affect bits above 31.
- **Stage S2 (registers W_mul_valid, W_mul_result, W_mul_tag)**
  - W_mul_result <= (s1_lo + {s1_mid, 16'h0}) mod 2^32.
  - The carry out of bit 31 is dropped.
- **Elastic control**
  - s2_adv = ~W_mul_valid | W_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - M_mul_stall = ~s1_adv (combinational; no dependency on M_mul_valid).
- **Input accept**
  - Input transfer occurs when M_mul_valid & ~M_mul_stall.
  - On transfer, S1 loads the new partial products and tag.
  - If s1_adv is high but there is no transfer, s1_valid <= 0.
- **S1 to S2**
  - When s2_adv: W_mul_valid <= s1_valid, and data/tag load from S1 if s1_valid.
  - When ~s2_adv: S2 holds all of its registers.
- **Simultaneous events**
  - When W_ready, a full S2 and a full S1 coincide with a new input, all three move in the same cycle.
  - Throughput is one result per cycle.
- **Data registers**
  - Data registers load only when their stage loads valid data.
  - When invalid, their contents are don't-care but must be deterministic after reset.

## Timing
- **Reset (async assert)**
  - s1_valid = 0, W_mul_valid = 0.
  - W_mul_result = 0, W_mul_tag = 0, s1_lo = s1_mid = s1_tag = 0.
  - M_mul_stall = 0.
- Reset deassertion takes effect at the first clk edge where reset_n is sampled high.
- **Latency:** an input accepted at edge N is presented on W_mul_valid/W_mul_result after edge N+1, i.e. 2 cycles, provided W_ready stays high.
- **Backpressure**
  - With W_ready low, at most 2 results are buffered (S1 + S2).
  - M_mul_stall rises in the cycle where both stages are valid and W_ready is low.
  - M_mul_stall falls in the same cycle W_ready rises; this is a combinational path.
- **Output stability:** while W_mul_valid & ~W_ready, W_mul_result and W_mul_tag must remain stable.
- **Reset mid-operation:** both in-flight results are discarded; no W_mul_valid pulse after reset releases.
- **Critical path:** S1 contains a 16-bit add; S2 contains a 32-bit add with only the upper 16 bits non-trivial.

## Test plan
- **All-ones operands:** src1 = src2 = 0xFFFFFFFF, giving p1 = p2 = p3 = 0xFFFE0001, tag 3, W_ready = 1. Required: W_mul_result = 0x00000001 and W_mul_tag = 3, exactly 2 cycles after accept.
- **Mixed operands:** src1 = 0x00012345, src2 = 0x00000010, giving p1 = 0x00023450, p2 = 0, p3 = 0x10. Required: W_mul_result = 0x00123450.
- **Back-to-back stream:** 8 consecutive valid inputs with W_ready = 1. Required: 8 consecutive W_mul_valid cycles with results in order, and M_mul_stall never asserted.
- **Backpressure:** W_ready held low while 3 inputs are presented. Required:
  - The first 2 inputs are accepted.
  - M_mul_stall = 1 on the third input.
  - W_mul_result is stable throughout.
  - On W_ready = 1, the third input is accepted in that cycle and all 3 results emerge in order with no loss or duplication.
- **Reset mid-operation:** assert reset_n = 0 asynchronously while both stages are valid. Required:
  - W_mul_valid = 0 and M_mul_stall = 0 immediately.
  - No output appears after release until a new input arrives.
- **Random compare:** 10k random operand pairs with random M_mul_valid and W_ready. Required: W_mul_result equals (src1 * src2) mod 2^32 against a reference model, with tags matching in order.
